fpu_add_arbiter: RTL

- Shares one pipelined single-precision floating_point_add instance (fixed latency, no backpressure) between NUM_REQ requesters, e.g. the FPU decode port and a vector/accumulate sequencer.
- Grants at most one operation per cycle using round-robin, and tags each issued operation with its requester ID.
- Routes each adder result back to its originating requester.
- Limits per-requester outstanding operations and flags any tag/valid misalignment.

---
 rtl/fpu_add_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fpu_add_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined FP adder between
// NUM_REQ requesters, with per-requester credit limits and result routing.
module fpu_add_arbiter #(
   parameter int NUM_REQ         = 4,
   parameter int DATA_WIDTH      = 32,
   parameter int LATENCY         = 13,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ID_WIDTH        = $clog2(NUM_REQ)
) (
   input  logic                          clkIn,
   input  logic                          rstIn,
   input  logic [NUM_REQ-1:0]            reqValidIn,
   output logic [NUM_REQ-1:0]            reqReadyOut,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataAIn,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] reqDataBIn,
   output logic [NUM_REQ-1:0]            rspValidOut,
   output logic [DATA_WIDTH-1:0]         rspDataOut,
   output logic [DATA_WIDTH-1:0]         addDataAOut,
   output logic [DATA_WIDTH-1:0]         addDataBOut,
   output logic                          addValidOut,
   input  logic [DATA_WIDTH-1:0]         addDataIn,
   input  logic                          addValidIn,
   output logic                          errorOut
);

   localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);

   logic [ID_WIDTH-1:0]   rrPtr;
   logic [CNT_WIDTH-1:0]  cnt [NUM_REQ];
   logic [NUM_REQ-1:0]    eligible;
   logic [DATA_WIDTH-1:0] opA [NUM_REQ];
   logic [DATA_WIDTH-1:0] opB [NUM_REQ];

   logic                  grantFound;
   logic [ID_WIDTH-1:0]   grantId;
   logic [ID_WIDTH:0]     scanSum;
   logic                  accept;

   logic [LATENCY:0]      tagValid;
   logic [ID_WIDTH-1:0]   tagId [LATENCY+1];
   logic                  finalValid;
   logic [ID_WIDTH-1:0]   finalId;
   logic                  retire;
   logic                  mismatch;
   logic [NUM_REQ-1:0]    finalOneHot;

   // A requester competes only while it has a free credit.
   for (genvar i = 0; i < NUM_REQ; i++) begin : gUnpack
      assign opA[i]      = reqDataAIn[i*DATA_WIDTH +: DATA_WIDTH];
      assign opB[i]      = reqDataBIn[i*DATA_WIDTH +: DATA_WIDTH];
      assign eligible[i] = reqValidIn[i] && (cnt[i] < CNT_WIDTH'(MAX_OUTSTANDING));
   end

   always_comb begin
      grantFound  = 1'b0;
      grantId     = '0;
      scanSum     = '0;
      reqReadyOut = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scanSum = {1'b0, rrPtr} + (ID_WIDTH+1)'(k);
         if (scanSum >= (ID_WIDTH+1)'(NUM_REQ)) begin
            scanSum = scanSum - (ID_WIDTH+1)'(NUM_REQ);
         end
         if (!grantFound && eligible[scanSum[ID_WIDTH-1:0]]) begin
            grantFound = 1'b1;
            grantId    = scanSum[ID_WIDTH-1:0];
         end
      end
      if (grantFound) begin
         reqReadyOut[grantId] = 1'b1;
      end
   end

   assign accept = |(reqValidIn & reqReadyOut);

   // Issue stage: operands and valid go to the adder one edge after accept.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         addValidOut <= 1'b0;
         addDataAOut <= '0;
         addDataBOut <= '0;
         rrPtr       <= '0;
      end else begin
         addValidOut <= accept;
         if (accept) begin
            addDataAOut <= opA[grantId];
            addDataBOut <= opB[grantId];
            rrPtr       <= (grantId == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
         end
      end
   end

   // Tag pipeline mirrors the adder so the last stage lines up with addValidIn.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         tagValid <= '0;
         for (int s = 0; s <= LATENCY; s++) begin
            tagId[s] <= '0;
         end
      end else begin
         tagValid[0] <= accept;
         tagId[0]    <= accept ? grantId : '0;
         for (int s = 1; s <= LATENCY; s++) begin
            tagValid[s] <= tagValid[s-1];
            tagId[s]    <= tagId[s-1];
         end
      end
   end

   assign finalValid  = tagValid[LATENCY];
   assign finalId     = tagId[LATENCY];
   assign retire      = addValidIn && finalValid;
   assign mismatch    = addValidIn != finalValid;
   assign finalOneHot = NUM_REQ'(1) << finalId;

   // Results are steered back by tag; a misaligned valid produces no response.
   always_ff @(posedge clkIn or posedge rstIn) begin
      if (rstIn) begin
         rspValidOut <= '0;
         rspDataOut  <= '0;
         errorOut    <= 1'b0;
      end else begin
         rspValidOut <= retire ? finalOneHot : '0;
         if (retire) begin
            rspDataOut <= addDataIn;
         end
         if (mismatch) begin
            errorOut <= 1'b1;
         end
      end
   end

   // Credits: accept and retire of the same requester on one edge cancel out.
   for (genvar i = 0; i < NUM_REQ; i++) begin : gCnt
      logic incr;
      logic decr;
      assign incr = accept && (grantId == ID_WIDTH'(i));
      assign decr = retire && (finalId == ID_WIDTH'(i));
      always_ff @(posedge clkIn or posedge rstIn) begin
         if (rstIn) begin
            cnt[i] <= '0;
         end else if (incr && !decr) begin
            cnt[i] <= cnt[i] + 1'b1;
         end else if (decr && !incr) begin
            cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

endmodule
